// File: rtl/zeroriscy_perf_counters_pkg.sv
// Shared definitions for the zero-riscy performance-monitor unit: CSR map,
// CSR operation encodings and the read-modify-write helper.
package zeroriscy_perf_counters_pkg;

  // Same encodings as the core's CSR operation field.
  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [11:0] PERF_CNT_LO_BASE = 12'h780;
  localparam logic [11:0] PERF_CNT_HI_BASE = 12'h790;
  localparam logic [11:0] PERF_EVTSEL_BASE = 12'h7A0;
  localparam logic [11:0] PERF_PCMR        = 12'h7B0;
  localparam logic [11:0] PERF_OVF         = 12'h7B1;

  localparam int EVTSEL_IRQ_EN_BIT = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CNT_LO,
    REG_CNT_HI,
    REG_EVTSEL,
    REG_PCMR,
    REG_OVF
  } reg_sel_e;

  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] wdata,
                                            input logic [31:0] q);
    logic [31:0] res;
    res = q;
    case (csr_op_e'(op))
      CSR_OP_WRITE: res = wdata;
      CSR_OP_SET:   res = wdata | q;
      CSR_OP_CLEAR: res = ~wdata & q;
      default:      res = q;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/zeroriscy_perf_counter.sv
// One counter slice: registered increment, wrap/saturate update, split
// lo/hi software write ports and a single-edge overflow pulse.
module zeroriscy_perf_counter
  import zeroriscy_perf_counters_pkg::*;
#(
  parameter int CNT_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 evt,
  input  logic                 sat_mode,
  input  logic                 lo_we,
  input  logic                 hi_we,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf_set
);

  localparam bit HAS_HI = (CNT_WIDTH > 32);

  logic                 inc_p1;
  logic                 at_max;
  logic                 wr;
  logic [31:0]          cnt_hi;
  logic [CNT_WIDTH-1:0] cnt_wr;

  assign at_max = &cnt;
  // A narrow counter has no high half, so a CNT_HI write must not steal an increment.
  assign wr     = lo_we | (hi_we & HAS_HI);
  assign cnt_hi = 32'(64'(cnt) >> 32);
  assign cnt_wr = CNT_WIDTH'({hi_we ? wdata : cnt_hi, lo_we ? wdata : cnt[31:0]});

  // A software write drops the colliding increment, including its overflow.
  assign ovf_set = inc_p1 & at_max & ~wr;

  // Stage p1: selected event registered
  always_ff @(posedge clk) begin
    if (rst) inc_p1 <= 1'b0;
    else     inc_p1 <= evt;
  end

  // Stage p2: counter update
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr) begin
      cnt <= cnt_wr;
    end else if (inc_p1 && !(at_max && sat_mode)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/zeroriscy_perf_counters.sv
// Performance-monitor unit answering CSR 0x780-0x7BF: N_CNT event counters
// with per-counter event select, global enable/saturate, sticky OVF and irq.
module zeroriscy_perf_counters
  import zeroriscy_perf_counters_pkg::*;
#(
  parameter int N_CNT     = 4,
  parameter int CNT_WIDTH = 48,
  parameter int N_EVENTS  = 16,
  parameter int EVT_IDX_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_access_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  input  logic [1:0]          csr_op_i,
  output logic [31:0]         csr_rdata_o,
  output logic                csr_hit_o,
  input  logic [N_EVENTS-1:0] events_i,
  output logic                irq_o
);

  localparam int EVT_SPACE = 1 << EVT_IDX_W;

  reg_sel_e              sel;
  logic [3:0]            idx;
  logic [31:0]           rdata;
  logic [31:0]           wval;
  logic                  we;

  logic [CNT_WIDTH-1:0]  cnt [N_CNT];
  logic [EVT_IDX_W-1:0]  evt_idx [N_CNT];
  logic [N_CNT-1:0]      irq_en;
  logic [N_CNT-1:0]      ovf_set;
  logic [N_CNT-1:0]      ovf_q;
  logic [N_CNT-1:0]      ovf_n;
  logic [1:0]            pcmr;
  logic                  irq_q;
  logic [EVT_SPACE-1:0]  evt_pad;

  assign idx = csr_addr_i[3:0];

  always_comb begin
    sel = REG_NONE;
    if (csr_access_i) begin
      case (csr_addr_i[11:4])
        PERF_CNT_LO_BASE[11:4]: if (32'(idx) < N_CNT) sel = REG_CNT_LO;
        PERF_CNT_HI_BASE[11:4]: if (32'(idx) < N_CNT) sel = REG_CNT_HI;
        PERF_EVTSEL_BASE[11:4]: if (32'(idx) < N_CNT) sel = REG_EVTSEL;
        PERF_PCMR[11:4]: begin
          if (idx == PERF_PCMR[3:0])     sel = REG_PCMR;
          else if (idx == PERF_OVF[3:0]) sel = REG_OVF;
        end
        default: sel = REG_NONE;
      endcase
    end
  end

  assign csr_hit_o = (sel != REG_NONE);

  always_comb begin
    rdata = '0;
    case (sel)
      REG_CNT_LO: begin
        for (int i = 0; i < N_CNT; i++)
          if (idx == 4'(i)) rdata = cnt[i][31:0];
      end
      REG_CNT_HI: begin
        for (int i = 0; i < N_CNT; i++)
          if (idx == 4'(i)) rdata = 32'(64'(cnt[i]) >> 32);
      end
      REG_EVTSEL: begin
        for (int i = 0; i < N_CNT; i++) begin
          if (idx == 4'(i)) begin
            rdata[EVT_IDX_W-1:0]      = evt_idx[i];
            rdata[EVTSEL_IRQ_EN_BIT] = irq_en[i];
          end
        end
      end
      REG_PCMR: rdata[1:0]       = pcmr;
      REG_OVF:  rdata[N_CNT-1:0] = ovf_q;
      default:  rdata = '0;
    endcase
  end

  assign csr_rdata_o = rdata;
  assign wval        = csr_apply(csr_op_i, csr_wdata_i, rdata);
  assign we          = csr_hit_o & (csr_op_e'(csr_op_i) != CSR_OP_NONE);

  // Indices at or beyond N_EVENTS land on zero padding and never count.
  always_comb begin
    evt_pad = '0;
    for (int j = 0; j < N_EVENTS && j < EVT_SPACE; j++) evt_pad[j] = events_i[j];
  end

  for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
    logic evt_sel;
    logic lo_we;
    logic hi_we;

    assign evt_sel = pcmr[0] & evt_pad[evt_idx[i]];
    assign lo_we   = we & (sel == REG_CNT_LO) & (idx == 4'(i));
    assign hi_we   = we & (sel == REG_CNT_HI) & (idx == 4'(i));

    zeroriscy_perf_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .evt      (evt_sel),
      .sat_mode (pcmr[1]),
      .lo_we    (lo_we),
      .hi_we    (hi_we),
      .wdata    (wval),
      .cnt      (cnt[i]),
      .ovf_set  (ovf_set[i])
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        evt_idx[i] <= '0;
        irq_en[i]  <= 1'b0;
      end else if (we && sel == REG_EVTSEL && idx == 4'(i)) begin
        evt_idx[i] <= wval[EVT_IDX_W-1:0];
        irq_en[i]  <= wval[EVTSEL_IRQ_EN_BIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         pcmr <= 2'b01;
    else if (we && sel == REG_PCMR)  pcmr <= wval[1:0];
  end

  // Hardware overflow is OR-ed in last so it beats a same-cycle clear.
  always_comb begin
    ovf_n = ovf_q;
    if (we && sel == REG_OVF) ovf_n = wval[N_CNT-1:0];
    ovf_n = ovf_n | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_n;
      irq_q <= |(ovf_n & irq_en);
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_zeroriscy_perf_counters.sv
// Directed bench for zeroriscy_perf_counters: CSR vector table plus
// sequences for counting, wrap, saturate, collisions and reset.
module tb_zeroriscy_perf_counters;

  localparam logic [1:0] OP_N = 2'b00;
  localparam logic [1:0] OP_W = 2'b01;
  localparam logic [1:0] OP_S = 2'b10;
  localparam logic [1:0] OP_C = 2'b11;

  logic        clk;
  logic        rst;
  logic        csr_access;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_op;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic [15:0] events;
  logic        irq;
  logic [31:0] csr_rdata2;
  logic        csr_hit2;
  logic        irq2;

  logic [31:0] rd1, rd2;
  logic        hit1, hit2;
  int          checks = 0;
  int          errors = 0;

  zeroriscy_perf_counters dut (
    .clk          (clk),
    .rst          (rst),
    .csr_access_i (csr_access),
    .csr_addr_i   (csr_addr),
    .csr_wdata_i  (csr_wdata),
    .csr_op_i     (csr_op),
    .csr_rdata_o  (csr_rdata),
    .csr_hit_o    (csr_hit),
    .events_i     (events),
    .irq_o        (irq)
  );

  zeroriscy_perf_counters #(.N_CNT(2), .CNT_WIDTH(32)) dut32 (
    .clk          (clk),
    .rst          (rst),
    .csr_access_i (csr_access),
    .csr_addr_i   (csr_addr),
    .csr_wdata_i  (csr_wdata),
    .csr_op_i     (csr_op),
    .csr_rdata_o  (csr_rdata2),
    .csr_hit_o    (csr_hit2),
    .events_i     (events),
    .irq_o        (irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] wd, input logic [31:0] er,
                              input logic eh);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.exp_rd = er; v.exp_hit = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One CSR access cycle; read data is sampled before the edge that writes.
  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    @(negedge clk);
    csr_access = 1'b1; csr_addr = addr; csr_op = op; csr_wdata = wd;
    #1;
    rd1 = csr_rdata; hit1 = csr_hit; rd2 = csr_rdata2; hit2 = csr_hit2;
    @(posedge clk);
    #1;
    csr_access = 1'b0; csr_op = OP_N; csr_wdata = '0;
  endtask

  task automatic rdchk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr(OP_N, addr, 32'h0);
    chk(name, 64'(rd1), 64'(exp));
  endtask

  task automatic pulse(input logic [15:0] mask);
    @(negedge clk); events = mask;
    @(negedge clk); events = '0;
  endtask

  // Event sampled into the increment stage right before a colliding CSR write.
  task automatic collide(input logic [15:0] mask, input logic [1:0] op,
                         input logic [11:0] addr, input logic [31:0] wd);
    @(negedge clk); events = mask;
    @(posedge clk); #1; events = '0;
    csr(op, addr, wd);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; events = '0;
  endtask

  vec_t vecs[27];

  initial begin
    rst = 1'b1; csr_access = 1'b0; csr_addr = '0; csr_wdata = '0; csr_op = OP_N; events = '0;

    vecs[0]  = mk(OP_N, 12'h7B0, 32'h0,        32'h1,        1'b1);
    vecs[1]  = mk(OP_N, 12'h7B1, 32'h0,        32'h0,        1'b1);
    vecs[2]  = mk(OP_N, 12'h780, 32'h0,        32'h0,        1'b1);
    vecs[3]  = mk(OP_N, 12'h793, 32'h0,        32'h0,        1'b1);
    vecs[4]  = mk(OP_S, 12'h7A2, 32'h103,      32'h0,        1'b1);
    vecs[5]  = mk(OP_C, 12'h7A2, 32'h001,      32'h103,      1'b1);
    vecs[6]  = mk(OP_N, 12'h7A2, 32'h0,        32'h102,      1'b1);
    vecs[7]  = mk(OP_W, 12'h783, 32'hDEADBEEF, 32'h0,        1'b1);
    vecs[8]  = mk(OP_W, 12'h793, 32'h1234ABCD, 32'h0,        1'b1);
    vecs[9]  = mk(OP_N, 12'h783, 32'h0,        32'hDEADBEEF, 1'b1);
    vecs[10] = mk(OP_S, 12'h783, 32'h10,       32'hDEADBEEF, 1'b1);
    vecs[11] = mk(OP_N, 12'h783, 32'h0,        32'hDEADBEFF, 1'b1);
    vecs[12] = mk(OP_N, 12'h793, 32'h0,        32'h0000ABCD, 1'b1);
    vecs[13] = mk(OP_C, 12'h793, 32'h0000000F, 32'h0000ABCD, 1'b1);
    vecs[14] = mk(OP_N, 12'h793, 32'h0,        32'h0000ABC0, 1'b1);
    vecs[15] = mk(OP_W, 12'h7A1, 32'hFFFFFFFF, 32'h0,        1'b1);
    vecs[16] = mk(OP_N, 12'h7A1, 32'h0,        32'h11F,      1'b1);
    vecs[17] = mk(OP_W, 12'h7A1, 32'h0,        32'h11F,      1'b1);
    vecs[18] = mk(OP_N, 12'h784, 32'h0,        32'h0,        1'b0);
    vecs[19] = mk(OP_W, 12'h784, 32'hFFFF,     32'h0,        1'b0);
    vecs[20] = mk(OP_N, 12'h794, 32'h0,        32'h0,        1'b0);
    vecs[21] = mk(OP_N, 12'h7A4, 32'h0,        32'h0,        1'b0);
    vecs[22] = mk(OP_N, 12'h7B2, 32'h0,        32'h0,        1'b0);
    vecs[23] = mk(OP_N, 12'h7BF, 32'h0,        32'h0,        1'b0);
    vecs[24] = mk(OP_N, 12'h770, 32'h0,        32'h0,        1'b0);
    vecs[25] = mk(OP_N, 12'h7A2, 32'h0,        32'h102,      1'b1);
    vecs[26] = mk(OP_W, 12'h7A2, 32'h0,        32'h102,      1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("idle_rdata", 64'(csr_rdata), 64'h0);
    chk("idle_hit",   64'(csr_hit),   64'h0);
    chk("reset_irq",  64'(irq),       64'h0);

    for (int k = 0; k < 27; k++) begin
      csr(vecs[k].op, vecs[k].addr, vecs[k].wdata);
      chk($sformatf("vec%0d_rdata", k), 64'(rd1),  64'(vecs[k].exp_rd));
      chk($sformatf("vec%0d_hit", k),   64'(hit1), 64'(vecs[k].exp_hit));
    end

    // Cycle count with one-edge pipeline offset, then freeze with a one-cycle tail.
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; events = 16'h0001;
    repeat (100) @(posedge clk);
    #1; csr_access = 1'b1; csr_addr = 12'h780; csr_op = OP_N;
    #1; chk("cycle_lo", 64'(csr_rdata), 64'd99);
    csr_addr = 12'h790;
    #1; chk("cycle_hi", 64'(csr_rdata), 64'd0);
    csr_access = 1'b0;
    csr(OP_W, 12'h7B0, 32'h0);
    repeat (3) @(posedge clk);
    rdchk("freeze_lo0", 12'h780, 32'd101);
    rdchk("freeze_lo1", 12'h781, 32'd101);
    events = '0;

    // Wrap with interrupt, then clear
    do_reset();
    csr(OP_W, 12'h7A1, 32'h103);
    csr(OP_W, 12'h791, 32'hFFFF);
    csr(OP_W, 12'h781, 32'hFFFFFFFE);
    for (int p = 0; p < 3; p++) pulse(16'h0008);
    rdchk("wrap_lo", 12'h781, 32'h1);
    rdchk("wrap_hi", 12'h791, 32'h0);
    rdchk("wrap_ovf", 12'h7B1, 32'h2);
    chk("wrap_irq", 64'(irq), 64'h1);
    csr(OP_C, 12'h7B1, 32'h2);
    chk("irq_clear", 64'(irq), 64'h0);
    rdchk("ovf_clear", 12'h7B1, 32'h0);

    // Out-of-range event index never counts
    csr(OP_W, 12'h7A2, 32'd20);
    @(negedge clk); events = 16'hFFFF;
    repeat (4) @(posedge clk);
    #1; events = '0;
    repeat (2) @(posedge clk);
    rdchk("bad_idx_lo", 12'h782, 32'h0);

    // Saturate mode
    csr(OP_W, 12'h7B0, 32'h3);
    csr(OP_W, 12'h7A3, 32'h5);
    csr(OP_W, 12'h793, 32'hFFFF);
    csr(OP_W, 12'h783, 32'hFFFFFFFF);
    for (int p = 0; p < 5; p++) pulse(16'h0020);
    repeat (2) @(posedge clk);
    rdchk("sat_lo", 12'h783, 32'hFFFFFFFF);
    rdchk("sat_hi", 12'h793, 32'h0000FFFF);
    rdchk("sat_ovf", 12'h7B1, 32'h8);
    chk("sat_irq_masked", 64'(irq), 64'h0);

    // Write beats a colliding increment
    csr(OP_W, 12'h7B0, 32'h1);
    csr(OP_W, 12'h7A0, 32'h6);
    csr(OP_W, 12'h790, 32'h0);
    csr(OP_W, 12'h780, 32'h10);
    collide(16'h0040, OP_W, 12'h780, 32'h100);
    rdchk("coll_lo", 12'h780, 32'h100);
    rdchk("coll_hi", 12'h790, 32'h0);

    // Dropped increment at max sets no overflow; lo write keeps hi
    csr(OP_W, 12'h790, 32'hFFFF);
    csr(OP_W, 12'h780, 32'hFFFFFFFF);
    collide(16'h0040, OP_W, 12'h780, 32'h5);
    rdchk("coll_max_lo", 12'h780, 32'h5);
    rdchk("coll_max_hi", 12'h790, 32'hFFFF);
    rdchk("coll_max_ovf", 12'h7B1, 32'h8);

    // Hardware overflow beats a same-cycle software clear
    csr(OP_W, 12'h780, 32'hFFFFFFFF);
    collide(16'h0040, OP_C, 12'h7B1, 32'hF);
    rdchk("hw_wins_ovf", 12'h7B1, 32'h1);
    rdchk("hw_wins_lo", 12'h780, 32'h0);
    rdchk("hw_wins_hi", 12'h790, 32'h0);

    // 32-bit counter variant: CNT_HI hits but holds no state
    csr(OP_W, 12'h790, 32'h55);
    chk("w32_hi_hit", 64'(hit2), 64'h1);
    csr(OP_N, 12'h790, 32'h0);
    chk("w32_hi_rd", 64'(rd2), 64'h0);
    csr(OP_N, 12'h782, 32'h0);
    chk("w32_oor_hit", 64'(hit2), 64'h0);
    chk("w32_oor_rd",  64'(rd2),  64'h0);
    chk("w48_cnt2_hit", 64'(hit1), 64'h1);

    // Reset in the middle of counting with irq asserted
    csr(OP_W, 12'h7A1, 32'h100);
    csr(OP_W, 12'h791, 32'hFFFF);
    csr(OP_W, 12'h781, 32'hFFFFFFFF);
    @(negedge clk); events = 16'h0001;
    repeat (3) @(posedge clk);
    #1; chk("pre_rst_irq", 64'(irq), 64'h1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    #1; chk("rst_irq", 64'(irq), 64'h0);
    @(negedge clk); rst = 1'b0; events = '0;
    rdchk("rst_lo0", 12'h780, 32'h0);
    rdchk("rst_lo1", 12'h781, 32'h0);
    rdchk("rst_hi1", 12'h791, 32'h0);
    rdchk("rst_pcmr", 12'h7B0, 32'h1);
    rdchk("rst_ovf", 12'h7B1, 32'h0);
    rdchk("rst_evtsel1", 12'h7A1, 32'h0);
    chk("rst_irq2", 64'(irq2), 64'h0);
    #1;
    chk("end_idle_rdata", 64'(csr_rdata), 64'h0);
    chk("end_idle_hit",   64'(csr_hit),   64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
